lcd_write_arbiter: RTL and testbench
====================================

Name: lcd_write_arbiter

Overview:
- Shares the single LCD character-write channel between two requesters: A (keypad echo) and B (result formatter).
- Each requester pushes characters into a private FIFO.
- A round-robin scheduler with message locking selects the next character and drives the LCD module using the data_ready / lcd_busy edge handshake.
- Messages terminated by a "last" flag are never interleaved on the display.

Parameters:
DEPTH, 8, entries per requester FIFO (power of two, 2..16)
DATA_W, 8, character width in bits

Ports:
clock  input  1  system clock, all logic on rising edge
internal_reset  input  1  synchronous, active-high reset
lcd_busy  input  1  busy flag from LCD module
a_push  input  1  requester A write strobe
a_data  input  DATA_W  requester A character
a_last  input  1  marks the final character of A's message
a_full  output  1  A FIFO holds DEPTH entries
b_push  input  1  requester B write strobe
b_data  input  DATA_W  requester B character
b_last  input  1  marks the final character of B's message
b_full  output  1  B FIFO holds DEPTH entries
lcd_data  output  DATA_W  character presented to LCD module
data_ready  output  1  lcd_data valid, hold until lcd_busy rises
overflow  output  2  sticky, bit0=A, bit1=B: push dropped while full
idle  output  1  both FIFOs empty, FSM in IDLE, no lock held

Behaviour:
- Clocking and reset
  - One clock domain.
  - Reset is synchronous and active-high on internal_reset.
  - Reset has priority over every other action in the same cycle.
- Reset values
  - lcd_data=0, data_ready=0, overflow=0.
  - FIFOs empty, so a_full=b_full=0.
  - FSM=IDLE, lock=0, rr_next=A.
  - idle=1 from the first cycle after reset.
- FIFOs
  - Each entry is {last, data}.
  - A push is accepted when the strobe is high and full==0; full is evaluated from pre-edge state.
  - A push while full is dropped even if a pop occurs on the same edge; it sets the matching overflow bit.
  - Simultaneous push and pop on a non-full FIFO is legal; count is unchanged.
  - Pointers wrap modulo DEPTH.
- Selection, evaluated in IDLE
  - If lock=1, only the current owner is eligible.
  - If the owner's FIFO is empty, the FSM waits. The other requester is intentionally stalled.
  - If lock=0, rr_next is chosen if non-empty, otherwise the other requester if non-empty, otherwise no selection.
- FSM states
  - IDLE
    - Transition fires when lcd_busy==0 and a selection exists.
    - Pop the head, register it into lcd_data, set data_ready<=1, go to PRESENT.
    - Set owner to the selected requester.
    - If the popped last==0, set lock<=1.
    - If last==1, set lock<=0 and rr_next<=the other requester.
  - PRESENT
    - Hold lcd_data and data_ready=1.
    - When lcd_busy==1, set data_ready<=0 and go to BUSY.
  - BUSY
    - When lcd_busy==0, go to IDLE.
    - No new data_ready is raised in the same cycle lcd_busy falls.
- Latency and throughput
  - A push into an empty FIFO at edge N, with the FSM in IDLE and lcd_busy=0, gives data_ready=1 after edge N+1.
  - lcd_data changes only on the IDLE->PRESENT edge.
  - Minimum spacing is one IDLE cycle between consecutive characters.
- lcd_busy already high in IDLE: nothing is issued until it falls.
- Reset mid-operation
  - data_ready deasserts after the reset edge.
  - FIFO contents and any partial message are discarded.
  - overflow is cleared only by reset.
- idle is combinational from registered state.

Test Plan:
1. Reset then A pushes "H","I"(last); LCD model raises busy 2 cycles after data_ready and drops it 5 cycles later -> lcd_data sequence 0x48, 0x49; data_ready high after the edge following the first push; idle=1 at end.
2. A pushes "AB"(B last) and B pushes "xy"(y last) on the same cycles -> output order A,B,x,y: no interleave, A goes first since rr_next=A after reset; rr_next=A after y.
3. A pushes "1" with last=0 and then goes silent; B pushes "z" -> only "1" is emitted, "z" stalls. A then pushes "2"(last) -> output "1","2","z".
4. B pushes DEPTH+1 characters with lcd_busy held high -> b_full=1 after the DEPTH-th push; overflow=2'b10 after the extra push; exactly DEPTH characters drain after busy releases.
5. Assert internal_reset while in PRESENT with 3 entries queued -> data_ready=0, FIFOs empty and overflow=0 after the reset edge; nothing is emitted while lcd_busy toggles.
6. lcd_busy held high with data queued -> data_ready stays 0; busy falls at cycle T -> data_ready=1 after edge T+1.

Source files
------------

// File: rtl/lcd_write_arbiter.sv
// Two-requester arbiter for the LCD character channel: per-requester FIFOs,
// round-robin selection with message locking, data_ready/lcd_busy handshake.
module lcd_write_arbiter #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              internal_reset,
    input  logic              lcd_busy,
    input  logic              a_push,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_full,
    input  logic              b_push,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_full,
    output logic [DATA_W-1:0] lcd_data,
    output logic              data_ready,
    output logic [1:0]        overflow,
    output logic              idle
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic REQ_A = 1'b0;

    typedef enum logic [1:0] {IDLE, PRESENT, BUSY} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] lcd_data_q, lcd_data_d;
    logic              data_ready_q, data_ready_d;
    logic              lock_q, lock_d;
    logic              owner_q, owner_d;
    logic              rr_next_q, rr_next_d;
    logic [1:0]        overflow_q, overflow_d;

    logic [DATA_W:0]   mem_q [2][DEPTH];
    logic [DATA_W:0]   mem_d [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  count_q [2];
    logic [CNT_W-1:0]  count_d [2];

    logic              push [2];
    logic [DATA_W:0]   push_entry [2];
    logic              full [2];
    logic              empty [2];
    logic              push_ok [2];
    logic              pop [2];
    logic              sel, sel_valid;
    logic [DATA_W:0]   head;

    assign push[0]       = a_push;
    assign push[1]       = b_push;
    assign push_entry[0] = {a_last, a_data};
    assign push_entry[1] = {b_last, b_data};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i]    = (count_q[i] == CNT_FULL);
            empty[i]   = (count_q[i] == '0);
            push_ok[i] = push[i] && !full[i];
        end
    end

    // A push against a full FIFO is dropped even when a pop frees a slot this edge.
    always_comb begin
        overflow_d = overflow_q | {push[1] && full[1], push[0] && full[0]};
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_d[i][j] = mem_q[i][j];
            end
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (push_ok[i]) begin
                mem_d[i][wr_ptr_q[i]] = push_entry[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_ONE;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
            end
            if (push_ok[i] && !pop[i]) begin
                count_d[i] = count_q[i] + CNT_ONE;
            end else if (!push_ok[i] && pop[i]) begin
                count_d[i] = count_q[i] - CNT_ONE;
            end
        end
    end

    // While a message is locked, the other requester stalls even if it has data.
    always_comb begin
        sel       = rr_next_q;
        sel_valid = 1'b0;
        if (lock_q) begin
            sel       = owner_q;
            sel_valid = !empty[owner_q];
        end else if (!empty[rr_next_q]) begin
            sel       = rr_next_q;
            sel_valid = 1'b1;
        end else if (!empty[~rr_next_q]) begin
            sel       = ~rr_next_q;
            sel_valid = 1'b1;
        end
        head = mem_q[sel][rd_ptr_q[sel]];
    end

    always_comb begin
        state_d      = state_q;
        lcd_data_d   = lcd_data_q;
        data_ready_d = data_ready_q;
        lock_d       = lock_q;
        owner_d      = owner_q;
        rr_next_d    = rr_next_q;
        pop[0]       = 1'b0;
        pop[1]       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!lcd_busy && sel_valid) begin
                    pop[0]       = (sel == REQ_A);
                    pop[1]       = (sel != REQ_A);
                    lcd_data_d   = head[DATA_W-1:0];
                    data_ready_d = 1'b1;
                    owner_d      = sel;
                    state_d      = PRESENT;
                    if (head[DATA_W]) begin
                        lock_d    = 1'b0;
                        rr_next_d = ~sel;
                    end else begin
                        lock_d = 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (lcd_busy) begin
                    data_ready_d = 1'b0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (!lcd_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (internal_reset) begin
            state_q      <= IDLE;
            lcd_data_q   <= '0;
            data_ready_q <= 1'b0;
            lock_q       <= 1'b0;
            owner_q      <= REQ_A;
            rr_next_q    <= REQ_A;
            overflow_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            lcd_data_q   <= lcd_data_d;
            data_ready_q <= data_ready_d;
            lock_q       <= lock_d;
            owner_q      <= owner_d;
            rr_next_q    <= rr_next_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[i][j] <= mem_d[i][j];
            end
        end
    end

    always_comb begin
        a_full     = full[0];
        b_full     = full[1];
        lcd_data   = lcd_data_q;
        data_ready = data_ready_q;
        overflow   = overflow_q;
        idle       = empty[0] && empty[1] && (state_q == IDLE) && !lock_q;
    end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed self-checking bench for lcd_write_arbiter with a simple LCD busy model.
module tb_lcd_write_arbiter;

   localparam int DEPTH  = 8;
   localparam int DATA_W = 8;

   logic              clock = 1'b0;
   logic              internalReset = 1'b1;
   logic              lcdBusy;
   logic              aPush = 1'b0;
   logic [DATA_W-1:0] aData = '0;
   logic              aLast = 1'b0;
   logic              aFull;
   logic              bPush = 1'b0;
   logic [DATA_W-1:0] bData = '0;
   logic              bLast = 1'b0;
   logic              bFull;
   logic [DATA_W-1:0] lcdData;
   logic              dataReady;
   logic [1:0]        overflow;
   logic              idle;

   logic              lcdAuto = 1'b0;
   logic              manualBusy = 1'b0;
   logic              modelBusy = 1'b0;
   int                modelCnt = 0;
   logic [7:0]        captured[$];
   logic [7:0]        expectedChars[$];

   int testsRun = 0;
   int testsFailed = 0;

   assign lcdBusy = lcdAuto ? modelBusy : manualBusy;

   lcd_write_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clock(clock),
      .internal_reset(internalReset),
      .lcd_busy(lcdBusy),
      .a_push(aPush),
      .a_data(aData),
      .a_last(aLast),
      .a_full(aFull),
      .b_push(bPush),
      .b_data(bData),
      .b_last(bLast),
      .b_full(bFull),
      .lcd_data(lcdData),
      .data_ready(dataReady),
      .overflow(overflow),
      .idle(idle)
   );

   // 10 ns clock; everything in the bench acts on the falling edge.
   always #5 clock = ~clock;

   // LCD model: raise busy two cycles after data_ready, drop it five cycles later,
   // and log each character at the moment it is accepted.
   initial begin
      forever begin
         @(negedge clock);
         if (!lcdAuto) begin
            modelBusy = 1'b0;
            modelCnt  = 0;
         end else if (!modelBusy) begin
            if (!dataReady) begin
               modelCnt = 0;
            end else if (modelCnt == 1) begin
               modelBusy = 1'b1;
               modelCnt  = 0;
               captured.push_back(lcdData);
            end else begin
               modelCnt++;
            end
         end else begin
            if (modelCnt == 4) begin
               modelBusy = 1'b0;
               modelCnt  = 0;
            end else begin
               modelCnt++;
            end
         end
      end
   end

   // Hard stop in case something wedges the main sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one set of push strobes across exactly one rising edge.
   task automatic applyStimulus(input logic ap, input logic [7:0] ad, input logic al,
                                input logic bp, input logic [7:0] bd, input logic bl);
      aPush = ap; aData = ad; aLast = al;
      bPush = bp; bData = bd; bLast = bl;
      @(negedge clock);
      aPush = 1'b0;
      bPush = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic resetDut();
      lcdAuto    = 1'b0;
      manualBusy = 1'b0;
      aPush      = 1'b0;
      bPush      = 1'b0;
      internalReset = 1'b1;
      waitCycles(2);
      internalReset = 1'b0;
      captured.delete();
      expectedChars.delete();
   endtask

   task automatic waitIdle(input string tag, input int n, input int budget);
      logic done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clock);
         if (idle && captured.size() >= n) done = 1'b1;
      end
      checkOutput(tag, done, 1);
   endtask

   task automatic checkCaptured(input string tag);
      checkOutput({tag, "_count"}, captured.size(), expectedChars.size());
      for (int i = 0; i < expectedChars.size(); i++) begin
         checkOutput($sformatf("%s_char%0d", tag, i),
                     (i < captured.size()) ? captured[i] : 8'hxx, expectedChars[i]);
      end
   endtask

   initial begin
      logic sawReady;

      // Reset values and a two-character message from A.
      resetDut();
      checkOutput("rst_lcd_data", lcdData, 0);
      checkOutput("rst_data_ready", dataReady, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_a_full", aFull, 0);
      checkOutput("rst_b_full", bFull, 0);
      checkOutput("rst_idle", idle, 1);
      lcdAuto = 1'b1;
      applyStimulus(1'b1, 8'h48, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("t1_dr_after_push", dataReady, 0);
      applyStimulus(1'b1, 8'h49, 1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput("t1_dr_next_edge", dataReady, 1);
      checkOutput("t1_first_data", lcdData, 8'h48);
      waitIdle("t1_done", 2, 200);
      expectedChars.push_back(8'h48);
      expectedChars.push_back(8'h49);
      checkCaptured("t1_seq");
      checkOutput("t1_idle_end", idle, 1);

      // Simultaneous messages: A first, no interleave, then round-robin returns to A.
      resetDut();
      lcdAuto = 1'b1;
      applyStimulus(1'b1, 8'h41, 1'b0, 1'b1, 8'h78, 1'b0);
      applyStimulus(1'b1, 8'h42, 1'b1, 1'b1, 8'h79, 1'b1);
      waitIdle("t2_msgs_done", 4, 400);
      applyStimulus(1'b1, 8'h70, 1'b1, 1'b1, 8'h71, 1'b1);
      waitIdle("t2_rr_done", 6, 400);
      expectedChars.push_back(8'h41);
      expectedChars.push_back(8'h42);
      expectedChars.push_back(8'h78);
      expectedChars.push_back(8'h79);
      expectedChars.push_back(8'h70);
      expectedChars.push_back(8'h71);
      checkCaptured("t2_seq");

      // Lock holds B off while A's message is unfinished.
      resetDut();
      lcdAuto = 1'b1;
      applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h7A, 1'b1);
      waitCycles(40);
      checkOutput("t3_stall_count", captured.size(), 1);
      checkOutput("t3_stall_idle", idle, 0);
      applyStimulus(1'b1, 8'h32, 1'b1, 1'b0, 8'h00, 1'b0);
      waitIdle("t3_done", 3, 400);
      expectedChars.push_back(8'h31);
      expectedChars.push_back(8'h32);
      expectedChars.push_back(8'h7A);
      checkCaptured("t3_seq");

      // Fill B with the LCD busy, overflow it, then drain.
      resetDut();
      manualBusy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'h61 + i), 1'b1);
         if (i == DEPTH - 2) checkOutput("t4_not_yet_full", bFull, 0);
      end
      checkOutput("t4_full", bFull, 1);
      checkOutput("t4_no_overflow_yet", overflow, 0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1);
      checkOutput("t4_overflow", overflow, 2'b10);
      checkOutput("t4_still_full", bFull, 1);
      checkOutput("t4_dr_while_busy", dataReady, 0);
      lcdAuto = 1'b1;
      manualBusy = 1'b0;
      waitIdle("t4_drain", DEPTH, 600);
      waitCycles(10);
      for (int i = 0; i < DEPTH; i++) expectedChars.push_back(8'(8'h61 + i));
      checkCaptured("t4_seq");
      checkOutput("t4_overflow_sticky", overflow, 2'b10);

      // Reset while a character is presented with more queued behind it.
      resetDut();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
      end
      checkOutput("t5_pre_dr", dataReady, 1);
      checkOutput("t5_pre_data", lcdData, 8'h30);
      checkOutput("t5_pre_overflow", overflow, 2'b10);
      internalReset = 1'b1;
      @(negedge clock);
      internalReset = 1'b0;
      checkOutput("t5_post_dr", dataReady, 0);
      checkOutput("t5_post_overflow", overflow, 0);
      checkOutput("t5_post_b_full", bFull, 0);
      checkOutput("t5_post_data", lcdData, 0);
      checkOutput("t5_post_idle", idle, 1);
      sawReady = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) manualBusy = ~manualBusy;
         @(negedge clock);
         sawReady = sawReady | dataReady;
      end
      checkOutput("t5_nothing_emitted", sawReady, 0);

      // Busy already high in IDLE, then the one-IDLE-cycle gap between characters.
      resetDut();
      manualBusy = 1'b1;
      applyStimulus(1'b1, 8'h51, 1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h52, 1'b1, 1'b0, 8'h00, 1'b0);
      waitCycles(3);
      checkOutput("t6_held_off", dataReady, 0);
      manualBusy = 1'b0;
      @(negedge clock);
      checkOutput("t6_dr_after_fall", dataReady, 1);
      checkOutput("t6_data_q", lcdData, 8'h51);
      manualBusy = 1'b1;
      @(negedge clock);
      checkOutput("t6_dr_busy", dataReady, 0);
      checkOutput("t6_data_held", lcdData, 8'h51);
      manualBusy = 1'b0;
      @(negedge clock);
      checkOutput("t6_gap_cycle", dataReady, 0);
      @(negedge clock);
      checkOutput("t6_second_dr", dataReady, 1);
      checkOutput("t6_data_r", lcdData, 8'h52);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
